gpio_irq: RTL and testbench

- Parametrised next-generation GPIO peripheral.
- Per-pin direction and output data, with atomic SET/CLR/TOGGLE write aliases.
- Configurable-depth input synchroniser.
- Per-pin interrupt detection (edge or level, selectable polarity) with sticky W1C status and a single aggregated interrupt line.
- Sits on the simple peripheral register bus next to the other SoC peripherals; irq_o goes to the interrupt controller.

---
 rtl/gpio_irq_if.sv | 21 ++
 rtl/gpio_irq.sv | 151 +++++++++++++++
 tb/tb_gpio_irq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: simple peripheral register bus.
//   addr  : byte address
//   wdata : write data
//   we    : single-cycle write strobe
//   re    : read strobe
//   rdata : read data, combinational from addr/re
// Bus semantics: there is no valid/ready handshake. A write takes effect on
// the rising clock edge where we is high. A read is purely combinational:
// rdata is valid in the same cycle re is high and is 0 whenever re is low.
// The slave never stalls.
// Modports: master drives addr/wdata/we/re; slave drives rdata.
interface gpio_irq_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: GPIO peripheral with per-pin direction and data registers,
// SET/CLR/TOG write aliases, an input synchroniser, and per-pin edge/level
// interrupt detection with sticky W1C status.
// Ports:
//   clk_i     : clock, all state changes on the rising edge
//   rst_ni    : asynchronous active-low reset
//   bus       : register bus (gpio_irq_if.slave), only addr[5:0] decoded
//   gpio_i    : asynchronous pin inputs
//   gpio_o    : pin output values (DATA register)
//   gpio_oe_o : output enables, 1 = drive (DIR register)
//   irq_o     : OR of STATUS & IRQ_EN
module gpio_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  gpio_irq_if.slave        bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  localparam logic [5:0] ADDR_DATA     = 6'h00;
  localparam logic [5:0] ADDR_DIR      = 6'h04;
  localparam logic [5:0] ADDR_INPUT    = 6'h08;
  localparam logic [5:0] ADDR_SET      = 6'h0C;
  localparam logic [5:0] ADDR_CLR      = 6'h10;
  localparam logic [5:0] ADDR_TOG      = 6'h14;
  localparam logic [5:0] ADDR_IRQ_EN   = 6'h18;
  localparam logic [5:0] ADDR_IRQ_TYPE = 6'h1C;
  localparam logic [5:0] ADDR_IRQ_POL  = 6'h20;
  localparam logic [5:0] ADDR_STATUS   = 6'h24;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_type_q;
  logic [WIDTH-1:0] irq_pol_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [5:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rd_val;

  assign addr  = bus.addr[5:0];
  assign wdata = bus.wdata[WIDTH-1:0];

  // Address bits above the decoded window are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:6];

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[31:WIDTH];
  end

  // Input synchroniser chain; sync_q[0] is the metastability-catching flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Per-bit event detection. prev_q resets to 0, so a pin already high at
  // reset release shows up as a rising edge once the chain fills.
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

  always_comb begin
    evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (irq_type_q[i]) evt[i] = irq_pol_q[i] ? rise[i] : fall[i];
      else               evt[i] = irq_pol_q[i] ? sync[i] : ~sync[i];
    end
  end

  assign w1c_mask = (bus.we && addr == ADDR_STATUS) ? wdata : '0;

  // STATUS: a new event wins over a same-cycle W1C of the same bit, which
  // also makes W1C ineffective while a level condition persists.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
      prev_q   <= '0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | evt;
      prev_q   <= sync;
    end
  end

  // Control registers. Writes to INPUT, STATUS (handled above) or unmapped
  // addresses leave these untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_type_q <= '0;
      irq_pol_q  <= '0;
    end else if (bus.we) begin
      case (addr)
        ADDR_DATA:     data_q     <= wdata;
        ADDR_DIR:      dir_q      <= wdata;
        ADDR_SET:      data_q     <= data_q | wdata;
        ADDR_CLR:      data_q     <= data_q & ~wdata;
        ADDR_TOG:      data_q     <= data_q ^ wdata;
        ADDR_IRQ_EN:   irq_en_q   <= wdata;
        ADDR_IRQ_TYPE: irq_type_q <= wdata;
        ADDR_IRQ_POL:  irq_pol_q  <= wdata;
        default: ;
      endcase
    end
  end

  // Read mux; write-only and unmapped addresses read as 0.
  always_comb begin
    rd_val = '0;
    if (bus.re) begin
      case (addr)
        ADDR_DATA:     rd_val = data_q;
        ADDR_DIR:      rd_val = dir_q;
        ADDR_INPUT:    rd_val = sync;
        ADDR_IRQ_EN:   rd_val = irq_en_q;
        ADDR_IRQ_TYPE: rd_val = irq_type_q;
        ADDR_IRQ_POL:  rd_val = irq_pol_q;
        ADDR_STATUS:   rd_val = status_q;
        default:       rd_val = '0;
      endcase
    end
  end

  assign bus.rdata = 32'(rd_val);
  assign gpio_o    = data_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed self-checking bench for gpio_irq (WIDTH=8,
// SYNC_STAGES=2). A table of register-access vectors covers the data path;
// hand-written sequences cover interrupt latency, W1C races, level mode,
// enable gating and asynchronous reset.
module tb_gpio_irq;

  localparam int W = 8;

  logic         clk_i;
  logic         rst_ni;
  logic [W-1:0] gpio_i;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_oe_o;
  logic         irq_o;

  gpio_irq_if bus ();

  gpio_irq #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Write lands on the posedge following the next negedge; returns #1 after it.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk_i);
    bus.addr  = {26'h0, a};
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk_i);
    #1;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  // Combinational read inside the current cycle, away from the edge.
  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    bus.addr = {26'h0, a};
    bus.re   = 1'b1;
    #1;
    d = bus.rdata;
    bus.re = 1'b0;
    #1;
  endtask

  // Pushes the expected value, reads, pops and compares.
  task automatic read_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [31:0] e;
    exp_q.push_back(exp);
    bus_read(a, d);
    e = exp_q.pop_front();
    chk(name, d, e);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_i);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [W-1:0] exp_gpio;
    logic [W-1:0] exp_oe;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    logic [31:0] d;

    vecs[0]  = '{"wr_dir",       1'b1, 6'h04, 32'hFF, 32'h0,  8'h00, 8'hFF};
    vecs[1]  = '{"wr_data",      1'b1, 6'h00, 32'hA5, 32'h0,  8'hA5, 8'hFF};
    vecs[2]  = '{"rd_data",      1'b0, 6'h00, 32'h0,  32'hA5, 8'hA5, 8'hFF};
    vecs[3]  = '{"rd_dir",       1'b0, 6'h04, 32'h0,  32'hFF, 8'hA5, 8'hFF};
    vecs[4]  = '{"wr_set",       1'b1, 6'h0C, 32'h0A, 32'h0,  8'hAF, 8'hFF};
    vecs[5]  = '{"wr_clr",       1'b1, 6'h10, 32'h81, 32'h0,  8'h2E, 8'hFF};
    vecs[6]  = '{"wr_tog",       1'b1, 6'h14, 32'hFF, 32'h0,  8'hD1, 8'hFF};
    vecs[7]  = '{"rd_set_zero",  1'b0, 6'h0C, 32'h0,  32'h0,  8'hD1, 8'hFF};
    vecs[8]  = '{"rd_data_tog",  1'b0, 6'h00, 32'h0,  32'hD1, 8'hD1, 8'hFF};
    vecs[9]  = '{"rd_unmapped",  1'b0, 6'h3C, 32'h0,  32'h0,  8'hD1, 8'hFF};
    vecs[10] = '{"wr_input_ro",  1'b1, 6'h08, 32'h55, 32'h0,  8'hD1, 8'hFF};
    vecs[11] = '{"rd_input",     1'b0, 6'h08, 32'h0,  32'h0,  8'hD1, 8'hFF};
    vecs[12] = '{"wr_unmapped",  1'b1, 6'h28, 32'h00, 32'h0,  8'hD1, 8'hFF};
    vecs[13] = '{"wr_irq_type",  1'b1, 6'h1C, 32'hFF, 32'h0,  8'hD1, 8'hFF};
    vecs[14] = '{"rd_irq_type",  1'b0, 6'h1C, 32'h0,  32'hFF, 8'hD1, 8'hFF};

    rst_ni    = 1'b0;
    gpio_i    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;

    // Reset state
    #12;
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_oe",     32'(gpio_oe_o), 32'h0);
    chk("rst_irq",    32'(irq_o), 32'h0);
    chk("rst_rdata",  bus.rdata, 32'h0);
    read_chk("rst_status", 6'h24, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycles(2);

    // Table-driven register path
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else               read_chk({vecs[i].name, "_rd"}, vecs[i].addr, vecs[i].exp_rd);
      chk({vecs[i].name, "_gpio"}, 32'(gpio_o), 32'(vecs[i].exp_gpio));
      chk({vecs[i].name, "_oe"},   32'(gpio_oe_o), 32'(vecs[i].exp_oe));
    end

    // rdata held at 0 while re is low, even on a mapped address
    bus.addr = 32'h0;
    #1;
    chk("re_low_rdata", bus.rdata, 32'h0);

    // Since reset, default level-low mode latched STATUS = 0xFF; edge mode
    // is now selected so W1C clears it for good.
    read_chk("status_level_default", 6'h24, 32'hFF);
    bus_write(6'h20, 32'h01);     // POL: bit0 rising, others falling
    bus_write(6'h24, 32'hFF);
    read_chk("status_cleared", 6'h24, 32'h0);
    bus_write(6'h18, 32'h01);     // EN bit0
    chk("irq_idle", 32'(irq_o), 32'h0);

    // Rising edge latency: pin changes before edge 1
    @(negedge clk_i);
    gpio_i[0] = 1'b1;
    cycles(1);
    read_chk("input_after_e1", 6'h08, 32'h0);
    cycles(1);
    read_chk("input_after_e2", 6'h08, 32'h01);
    read_chk("status_after_e2", 6'h24, 32'h0);
    chk("irq_after_e2", 32'(irq_o), 32'h0);
    cycles(1);
    read_chk("status_after_e3", 6'h24, 32'h01);
    chk("irq_after_e3", 32'(irq_o), 32'h1);
    bus_write(6'h24, 32'h01);
    chk("irq_after_w1c", 32'(irq_o), 32'h0);
    read_chk("status_after_w1c", 6'h24, 32'h0);

    // Falling edge in rising mode: no event
    @(negedge clk_i);
    gpio_i[0] = 1'b0;
    cycles(5);
    read_chk("status_fall_ignored", 6'h24, 32'h0);
    chk("irq_fall_ignored", 32'(irq_o), 32'h0);

    // Same-cycle rising event and W1C: set wins
    @(negedge clk_i);
    gpio_i[0] = 1'b1;
    @(posedge clk_i);             // edge 1
    @(posedge clk_i);             // edge 2
    bus_write(6'h24, 32'h01);     // lands on edge 3 with the event
    read_chk("status_set_wins", 6'h24, 32'h01);
    bus_write(6'h24, 32'h01);
    read_chk("status_w1c_later", 6'h24, 32'h0);

    // Level-low on bit 3
    @(negedge clk_i);
    gpio_i = '0;
    cycles(4);
    bus_write(6'h18, 32'h08);     // EN bit3
    bus_write(6'h1C, 32'hF7);     // bit3 level, rest edge
    bus_write(6'h24, 32'hFF);
    cycles(1);
    read_chk("level_w1c_ineffective", 6'h24, 32'h08);
    chk("level_irq", 32'(irq_o), 32'h1);
    @(negedge clk_i);
    gpio_i[3] = 1'b1;
    cycles(4);
    bus_write(6'h24, 32'h08);
    read_chk("level_cleared", 6'h24, 32'h0);
    chk("level_irq_clear", 32'(irq_o), 32'h0);

    // Enable gating and async reset
    bus_write(6'h18, 32'h00);
    bus_write(6'h1C, 32'hFF);
    bus_write(6'h20, 32'hFF);     // all rising, pins stable
    bus_write(6'h24, 32'hFF);
    @(negedge clk_i);
    gpio_i[0] = 1'b1;
    cycles(4);
    read_chk("gated_status", 6'h24, 32'h01);
    chk("gated_irq", 32'(irq_o), 32'h0);
    bus_write(6'h18, 32'h01);
    chk("enable_irq", 32'(irq_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_irq", 32'(irq_o), 32'h0);
    chk("async_rst_gpio", 32'(gpio_o), 32'h0);
    chk("async_rst_oe", 32'(gpio_oe_o), 32'h0);
    read_chk("async_rst_status", 6'h24, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycles(2);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
